// File: rtl/top_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package top_arb_pkg;

  // Arbiter is either idle (looking for a winner) or holding a grant for one burst.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Beat counter must be able to count up to depth_p without wrapping.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/top_arb_rr.sv
// Rotating-priority picker: first set request bit scanning from ptr upward, wrapping.
module top_arb_rr #(
  parameter int num_p = 3
) (
  input  logic [num_p-1:0]         req,
  input  logic [$clog2(num_p)-1:0] ptr,
  output logic [num_p-1:0]         gnt,
  output logic                     any_o
);

  logic found;

  // Scan offsets 0..num_p-1 from ptr; the first requesting position wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < num_p; i++) begin
      for (int j = 0; j < num_p; j++) begin
        if (!found && req[j] && (((int'(ptr) + i) % num_p) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any_o = |req;

endmodule

// File: rtl/top_arb.sv
// Round-robin burst arbiter feeding the single top_core data input.
// A grant is locked for one burst (or depth_p beats at most), then priority rotates.
module top_arb
  import top_arb_pkg::*;
#(
  parameter int width_p = 10,
  parameter int depth_p = 4,
  parameter int num_p   = 3
) (
  input  logic                       main_clk_i,
  input  logic                       main_rst_an_i,
  input  logic [num_p-1:0]           req_valid_i,
  input  logic [num_p*width_p-1:0]   req_data_i,
  input  logic [num_p-1:0]           req_last_i,
  output logic [num_p-1:0]           req_ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic [num_p-1:0]           grant_o,
  output logic                       busy_o
);

  localparam int ptr_w = $clog2(num_p);
  localparam int cnt_w = cnt_width(depth_p);

  arb_state_e         state_q, state_d;
  logic [num_p-1:0]   grant_q, grant_d;
  logic [ptr_w-1:0]   ptr_q, ptr_d;
  logic [ptr_w-1:0]   g_idx, ptr_inc;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [num_p-1:0]   rr_gnt;
  logic               rr_any;
  logic               last_sel;
  logic               xfer;
  logic               rel;

  top_arb_rr #(.num_p(num_p)) u_rr (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .any_o (rr_any)
  );

  // Route the granted requester to the downstream port; everything is zero while idle.
  always_comb begin
    data_o       = '0;
    data_valid_o = 1'b0;
    req_ready_o  = '0;
    last_sel     = 1'b0;
    g_idx        = '0;
    for (int k = 0; k < num_p; k++) begin
      if (grant_q[k]) begin
        data_o         = req_data_i[k*width_p +: width_p];
        data_valid_o   = req_valid_i[k];
        req_ready_o[k] = data_ready_i;
        last_sel       = req_last_i[k];
        g_idx          = ptr_w'(k);
      end
    end
  end

  assign ptr_inc = (g_idx == ptr_w'(num_p - 1)) ? '0 : g_idx + 1'b1;
  assign xfer    = data_valid_o & data_ready_i;
  assign rel     = xfer & (last_sel | (cnt_q == cnt_w'(depth_p - 1)));

  // Next-state: pick a winner when idle, count beats and release on last or at the depth cap.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d = GRANT;
          grant_d = rr_gnt;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ptr_inc;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, grant, pointer and beat counter registers.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_top_arb.sv
// Scoreboard bench for top_arb: randomized and directed bursts against a behavioural model.
module tb_top_arb;

  localparam int W = 10;
  localparam int D = 4;
  localparam int N = 3;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid_i;
  logic [N*W-1:0]   req_data_i;
  logic [N-1:0]     req_last_i;
  logic [N-1:0]     req_ready_o;
  logic [W-1:0]     data_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic [N-1:0]     grant_o;
  logic             busy_o;

  top_arb #(.width_p(W), .depth_p(D), .num_p(N)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_last_i    (req_last_i),
    .req_ready_o   (req_ready_o),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [W-1:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int         req;
    logic [W-1:0] data;
  } exp_t;

  beat_t      stim_q[$];
  exp_t       exp_q[$];
  logic       rdy_q[$];
  int         gap[N];
  logic [N-1:0] fired_v;
  bit         rdy_random;
  int         vectors;
  int         miscompares;

  // Reference model state: who owns the port, rotation start, beats so far.
  int         m_owner;
  int         m_ptr;
  int         m_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frontIdx(input int k);
    for (int i = 0; i < stim_q.size(); i++)
      if (stim_q[i].req == k) return i;
    return -1;
  endfunction

  function automatic int countReq(input int k);
    int c = 0;
    for (int i = 0; i < stim_q.size(); i++)
      if (stim_q[i].req == k) c++;
    return c;
  endfunction

  function automatic logic [31:0] onehot(input int k);
    logic [31:0] v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic pushBurst(input int k, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.req  = k;
      b.data = W'($urandom);
      b.last = (i == len - 1);
      stim_q.push_back(b);
    end
  endtask

  // One clock of stimulus: retire accepted beats, then present each requester's head beat.
  task automatic applyStimulus();
    int idx;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (fired_v[k]) begin
        idx = frontIdx(k);
        if (idx >= 0) stim_q.delete(idx);
      end
    end
    for (int k = 0; k < N; k++) begin
      idx = frontIdx(k);
      req_data_i[k*W +: W] = W'($urandom);
      req_last_i[k]        = 1'($urandom);
      if (gap[k] > 0) begin
        req_valid_i[k] = 1'b0;
        gap[k]--;
      end else if (idx >= 0) begin
        req_valid_i[k]       = 1'b1;
        req_data_i[k*W +: W] = stim_q[idx].data;
        req_last_i[k]        = stim_q[idx].last;
      end else begin
        req_valid_i[k] = 1'b0;
      end
    end
    if (rdy_q.size() > 0) data_ready_i = rdy_q.pop_front();
    else if (rdy_random)  data_ready_i = 1'($urandom);
    else                  data_ready_i = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((stim_q.size() > 0 || gap[0] > 0 || gap[1] > 0 || gap[2] > 0) && c < maxc) begin
      applyStimulus();
      c++;
    end
    applyStimulus();
    applyStimulus();
    if (c >= maxc) checkOutput("drain_timeout", 32'(stim_q.size()), 32'd0);
  endtask

  // Behavioural model: check grant/handshake outputs and predict transferred beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      exp_q.delete();
      checkOutput("rst_grant", 32'(grant_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_valid", 32'(data_valid_o), 32'd0);
      checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
      checkOutput("rst_data", 32'(data_o), 32'd0);
    end else begin
      checkOutput("grant", 32'(grant_o), onehot(m_owner));
      checkOutput("busy", 32'(busy_o), 32'(m_owner >= 0));
      if (m_owner < 0) begin
        checkOutput("idle_data", 32'(data_o), 32'd0);
        checkOutput("idle_valid", 32'(data_valid_o), 32'd0);
        checkOutput("idle_ready", 32'(req_ready_o), 32'd0);
        for (int i = 0; i < N; i++) begin
          if (m_owner < 0 && req_valid_i[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        end
      end else begin
        checkOutput("req_ready", 32'(req_ready_o), data_ready_i ? onehot(m_owner) : 32'd0);
        checkOutput("out_valid", 32'(data_valid_o), 32'(req_valid_i[m_owner]));
        if (req_valid_i[m_owner] && data_ready_i) begin
          exp_q.push_back('{req: m_owner, data: req_data_i[m_owner*W +: W]});
          m_cnt++;
          if (req_last_i[m_owner] || m_cnt == D) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt   = 0;
          end
        end
      end
    end
  end

  // Monitor: record accepted beats and compare every downstream transfer with the scoreboard.
  always @(negedge clk) begin
    int gi;
    exp_t e;
    #1;
    fired_v = req_valid_i & req_ready_o;
    if (rst_n && data_valid_o && data_ready_i) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (grant_o[k]) gi = k;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'(gi), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat_src", 32'(gi), 32'(e.req));
        checkOutput("beat_data", 32'(data_o), 32'(e.data));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    beat_t b;
    logic [W-1:0] pat[N];
    vectors = 0; miscompares = 0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    fired_v = '0; rdy_random = 1'b0;
    for (int k = 0; k < N; k++) gap[k] = 0;
    rst_n = 1'b0; req_valid_i = '0; req_data_i = '0; req_last_i = '0; data_ready_i = 1'b0;

    // Reset with random inputs; the model checks all outputs at zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid_i = N'($urandom); req_data_i = (N*W)'({$urandom, $urandom});
      req_last_i = N'($urandom); data_ready_i = 1'($urandom);
    end
    @(posedge clk); #1;
    req_valid_i = '0; data_ready_i = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus();

    // Round robin with single-beat bursts from all three requesters.
    $display("[TB] round robin");
    pat[0] = 10'h155; pat[1] = 10'h0AA; pat[2] = 10'h3FF;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        b.req = k; b.data = pat[k] ^ W'(r); b.last = 1'b1;
        stim_q.push_back(b);
      end
    drain(100);

    // Forced release: requester 1 bursts 6 beats, requester 2 competes.
    $display("[TB] forced release");
    pushBurst(1, 6);
    pushBurst(2, 2);
    drain(100);

    // Backpressure during a requester 0 burst.
    $display("[TB] backpressure");
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    pushBurst(0, 3);
    drain(100);

    // Valid gap: requester 2 pauses mid-burst while requester 0 waits.
    $display("[TB] valid gap");
    pushBurst(2, 3);
    c = 0;
    while (countReq(2) > 2 && c < 50) begin applyStimulus(); c++; end
    if (c >= 50) checkOutput("gap_timeout", 32'(countReq(2)), 32'd2);
    pushBurst(0, 1);
    gap[2] = 5;
    drain(100);

    // Reset in the middle of a 3-beat burst.
    $display("[TB] reset mid-burst");
    pushBurst(0, 3);
    c = 0;
    while (countReq(0) > 1 && c < 50) begin applyStimulus(); c++; end
    if (c >= 50) checkOutput("rstmid_timeout", 32'(countReq(0)), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_grant", 32'(grant_o), 32'd0);
    checkOutput("async_busy", 32'(busy_o), 32'd0);
    checkOutput("async_valid", 32'(data_valid_o), 32'd0);
    checkOutput("async_ready", 32'(req_ready_o), 32'd0);
    checkOutput("async_data", 32'(data_o), 32'd0);
    stim_q.delete();
    req_valid_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    pushBurst(1, 1);
    pushBurst(0, 1);
    drain(50);

    // Randomized traffic with random backpressure and occasional valid gaps.
    $display("[TB] random traffic");
    rdy_random = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (stim_q.size() < 8 && $urandom_range(0, 3) == 0)
        pushBurst($urandom_range(0, N - 1), $urandom_range(1, 7));
      if ($urandom_range(0, 40) == 0) gap[$urandom_range(0, N - 1)] = $urandom_range(1, 5);
      applyStimulus();
    end
    drain(3000);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
